ahb_gpio_irq: RTL and testbench

Second-generation AHB-Lite GPIO slave with a parametrised pin count. It adds a configurable input synchroniser, atomic set/clear/toggle of the output register, and per-pin interrupts (level or edge, selectable polarity) with sticky W1C status. It sits on the AHB matrix next to the other peripheral slaves and drives one combined interrupt line to the NVIC.

---
 rtl/ahb_gpio_irq.sv | 108 ++++++++++
 tb/tb_ahb_gpio_irq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_gpio_irq.sv
// ahb_gpio_irq: AHB-Lite GPIO slave with input synchroniser, atomic output ops and per-pin interrupts.
// Define GPIO_BOTH_EDGE_EN to add the IRQ_BOTH register (any-edge interrupts).
module ahb_gpio_irq #(
    parameter int GPIO_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic [1:0]            HRESP,
    output logic [GPIO_WIDTH-1:0] DIR,
    output logic [GPIO_WIDTH-1:0] WDATA,
    input  logic [GPIO_WIDTH-1:0] RDATA,
    output logic [GPIO_WIDTH-1:0] PIN_IRQ,
    output logic                  IRQ
);
    localparam int W = GPIO_WIDTH;
    logic            trans_en, wr_q, unused_ok;
    logic [3:0]      addr_q;
    logic [15:0]     wsel;
    logic [W-1:0]    wd, dir_q, out_q, en_q, type_q, pol_q, stat_q, both_q, prev_q, sync;
    logic [W-1:0]    rise, fall, evt, clr, stat_d, out_d, rd;
    logic [W-1:0]    sync_q [SYNC_STAGES];

    assign trans_en  = HSEL & HTRANS[1] & HREADY;
    assign unused_ok = ^{HSIZE, HPROT, HADDR[31:6], HADDR[1:0], HTRANS[0], HWDATA};
    assign HREADYOUT = 1'b1;
    assign HRESP     = 2'b00;
    assign wd        = HWDATA[W-1:0];
    assign wsel      = wr_q ? 16'd1 << addr_q : '0;
    assign sync      = sync_q[SYNC_STAGES-1];
    assign rise      = sync & ~prev_q;
    assign fall      = ~sync & prev_q;
    assign evt       = type_q & ((both_q & (rise | fall)) | (~both_q & ((pol_q & rise) | (~pol_q & fall))));
    assign clr       = wsel[9] ? wd : '0;
    // Edge bits are sticky with set beating a same-cycle W1C; level bits simply track the pin.
    assign stat_d    = (type_q & ((stat_q & ~clr) | evt)) | (~type_q & ~(sync ^ pol_q));
    assign out_d     = wsel[2] ? wd :
                       wsel[3] ? out_q | wd :
                       wsel[4] ? out_q & ~wd :
                       wsel[5] ? out_q ^ wd : out_q;
    assign DIR       = dir_q;
    assign WDATA     = out_q;
    assign PIN_IRQ   = stat_q & en_q;
    assign HRDATA    = 32'(rd);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
            dir_q  <= '0;
            out_q  <= '0;
            en_q   <= '0;
            type_q <= '0;
            pol_q  <= '0;
            stat_q <= '0;
            prev_q <= '0;
            IRQ    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            if (trans_en) addr_q <= HADDR[5:2];
            wr_q   <= trans_en & HWRITE;
            if (wsel[1]) dir_q <= wd;
            out_q  <= out_d;
            if (wsel[6]) en_q <= wd;
            if (wsel[7]) type_q <= wd;
            if (wsel[8]) pol_q <= wd;
            stat_q <= stat_d;
            prev_q <= sync;
            IRQ    <= |PIN_IRQ;
            sync_q[0] <= RDATA;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef GPIO_BOTH_EDGE_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) both_q <= '0;
        else if (wsel[10]) both_q <= wd;
    end
`else
    assign both_q = '0;
`endif

    always_comb begin
        rd = '0;
        case (addr_q)
            4'd0:    rd = sync;
            4'd1:    rd = dir_q;
            4'd2:    rd = out_q;
            4'd6:    rd = en_q;
            4'd7:    rd = type_q;
            4'd8:    rd = pol_q;
            4'd9:    rd = stat_q;
            4'd10:   rd = both_q;
            default: rd = '0;
        endcase
    end
endmodule

// File: tb/tb_ahb_gpio_irq.sv
// tb_ahb_gpio_irq: vector table, directed interrupt timing sequences and a randomised
// register/pin run against a behavioural model of the GPIO register file.
module tb_ahb_gpio_irq;
    localparam int W = 16;
    localparam logic [31:0] M = 32'h0000_FFFF;

    logic          HCLK = 0, HRESETn = 0, HSEL = 0, HWRITE = 0, HREADY = 1;
    logic [31:0]   HADDR = 0, HWDATA = 0;
    logic [1:0]    HTRANS = 0;
    logic [2:0]    HSIZE = 3'd2;
    logic [3:0]    HPROT = 0;
    logic          HREADYOUT, IRQ;
    logic [31:0]   HRDATA;
    logic [1:0]    HRESP;
    logic [W-1:0]  DIR, WDATA, PIN_IRQ, RDATA = 0;

    ahb_gpio_irq #(.GPIO_WIDTH(W), .SYNC_STAGES(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .DIR(DIR), .WDATA(WDATA),
        .RDATA(RDATA), .PIN_IRQ(PIN_IRQ), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    int vectors = 0, miscompares = 0;
    logic [31:0] rdv;
    logic [31:0] dir_m, out_m, en_m, type_m, pol_m, both_m, sticky_m, pins;

    typedef struct {
        bit          wr;
        logic [5:0]  off;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input bit wr, input logic [5:0] off, input logic [31:0] wd, output logic [31:0] rd);
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = {26'd0, off};
        @(negedge HCLK);
        HSEL = 0; HTRANS = 0; HWRITE = 0; HADDR = 0; HWDATA = wd;
        rd = HRDATA;
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] d);
        logic [31:0] x;
        bus(1, off, d, x);
    endtask

    task automatic rd_chk(input string name, input logic [5:0] off, input logic [31:0] exp);
        logic [31:0] x;
        bus(0, off, 0, x);
        chk(name, x, exp);
    endtask

    function automatic logic [31:0] stat_exp();
        return ((type_m & sticky_m) | (~type_m & ~(pins ^ pol_m))) & M;
    endfunction

    function automatic logic [31:0] read_exp(input int idx);
        case (idx)
            0: return pins;
            1: return dir_m;
            2: return out_m;
            6: return en_m;
            7: return type_m;
            8: return pol_m;
            9: return stat_exp();
`ifdef GPIO_BOTH_EDGE_EN
            10: return both_m;
`endif
            default: return 0;
        endcase
    endfunction

    initial begin
        tbl[0]  = '{1, 6'h08, 32'h0000_00F0, 0};
        tbl[1]  = '{1, 6'h0C, 32'h0000_0003, 0};
        tbl[2]  = '{1, 6'h10, 32'h0000_0010, 0};
        tbl[3]  = '{1, 6'h14, 32'h0000_0101, 0};
        tbl[4]  = '{0, 6'h08, 0, 32'h0000_01E2};
        tbl[5]  = '{0, 6'h0C, 0, 0};
        tbl[6]  = '{0, 6'h10, 0, 0};
        tbl[7]  = '{0, 6'h14, 0, 0};
        tbl[8]  = '{1, 6'h04, 32'h0001_2345, 0};
        tbl[9]  = '{0, 6'h04, 0, 32'h0000_2345};
        tbl[10] = '{1, 6'h28, 32'h0000_FFFF, 0};
`ifdef GPIO_BOTH_EDGE_EN
        tbl[11] = '{0, 6'h28, 0, 32'h0000_FFFF};
`else
        tbl[11] = '{0, 6'h28, 0, 0};
`endif
        tbl[12] = '{1, 6'h3C, 32'hFFFF_FFFF, 0};
        tbl[13] = '{0, 6'h3C, 0, 0};

        // reset state
        repeat (2) @(negedge HCLK);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_dir", 32'(DIR), 0);
        chk("rst_wdata", 32'(WDATA), 0);
        chk("rst_irq", 32'(IRQ), 0);
        chk("rst_pin_irq", 32'(PIN_IRQ), 0);
        chk("hreadyout", 32'(HREADYOUT), 1);
        chk("hresp", 32'(HRESP), 0);
        HRESETn = 1;
        // all pins low, POL=0, level mode: every STAT bit is an active level
        for (int i = 0; i <= 10; i++) rd_chk($sformatf("rst_rd_%0h", i * 4), 6'(i * 4), i == 9 ? M : 0);
        chk("rst_irq_after", 32'(IRQ), 0);

        foreach (tbl[i]) begin
            if (tbl[i].wr) wr(tbl[i].off, tbl[i].wd);
            else rd_chk($sformatf("tbl_%0d", i), tbl[i].off, tbl[i].exp);
        end
        chk("tbl_wdata", 32'(WDATA), 32'h01E2);
        chk("tbl_dir", 32'(DIR), 32'h2345);
        wr(6'h04, 0);
        wr(6'h28, 0);

        // pipelined write then read of the same register
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h08;
        @(negedge HCLK);
        HWDATA = 32'h55; HWRITE = 0; HADDR = 32'h08;
        @(negedge HCLK);
        HSEL = 0; HTRANS = 0; HADDR = 0;
        chk("b2b_read", HRDATA, 32'h55);
        chk("b2b_wdata", 32'(WDATA), 32'h55);

        // synchroniser latency: visible after edge k+1, not after edge k
        rd_chk("data_in_pre", 6'h00, 0);
        @(negedge HCLK); RDATA = 16'hA5A5;
        @(negedge HCLK); chk("data_in_early", HRDATA, 0);
        @(negedge HCLK); chk("data_in_sync", HRDATA, 32'hA5A5);
        RDATA = 0;
        repeat (4) @(negedge HCLK);

        // rising-edge interrupt on pin 3
        wr(6'h20, 32'hFFFF);
        wr(6'h1C, 32'h0008);
        wr(6'h18, 32'h0008);
        rd_chk("edge_stat0", 6'h24, 0);
        @(negedge HCLK); RDATA[3] = 1;
        repeat (4) @(negedge HCLK);
        chk("edge_irq", 32'(IRQ), 1);
        rd_chk("edge_stat", 6'h24, 32'h0008);
        wr(6'h24, 32'h0008);
        @(negedge HCLK);
        chk("w1c_irq_hold", 32'(IRQ), 1);
        chk("w1c_pin_irq", 32'(PIN_IRQ), 0);
        @(negedge HCLK);
        chk("w1c_irq_drop", 32'(IRQ), 0);
        @(negedge HCLK); RDATA[3] = 0;
        repeat (4) @(negedge HCLK);
        rd_chk("fall_ignored", 6'h24, 0);
        @(negedge HCLK); RDATA[3] = 1;
        wr(6'h24, 32'h0008);
        rd_chk("set_beats_clr", 6'h24, 32'h0008);

        // level interrupt, active low on pin 5
        wr(6'h1C, 0);
        @(negedge HCLK); RDATA = 0;
        wr(6'h20, 32'hFFDF);
        wr(6'h18, 32'h0020);
        repeat (3) @(negedge HCLK);
        chk("level_irq", 32'(IRQ), 1);
        wr(6'h24, 32'hFFFF);
        rd_chk("level_w1c", 6'h24, 32'h0020);
        @(negedge HCLK); RDATA[5] = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk($sformatf("level_hold_%0d", i), 32'(IRQ), 1);
        end
        @(negedge HCLK);
        chk("level_drop", 32'(IRQ), 0);

`ifdef GPIO_BOTH_EDGE_EN
        @(negedge HCLK); RDATA = 0;
        repeat (3) @(negedge HCLK);
        wr(6'h28, 32'h0004);
        wr(6'h1C, 32'h0004);
        rd_chk("both_stat0", 6'h24, 32'h0020);
        @(negedge HCLK); RDATA[2] = 1;
        repeat (4) @(negedge HCLK);
        rd_chk("both_rise", 6'h24, 32'h0024);
        wr(6'h24, 32'h0004);
        rd_chk("both_clr", 6'h24, 32'h0020);
        @(negedge HCLK); RDATA[2] = 0;
        repeat (4) @(negedge HCLK);
        rd_chk("both_fall", 6'h24, 32'h0024);
        wr(6'h28, 0);
`endif

        // randomised run against the register model
        pins = $urandom & M;
        @(negedge HCLK); RDATA = pins[W-1:0];
        wr(6'h1C, 0);
        type_m = 0; sticky_m = 0; both_m = 0;
        dir_m = $urandom & M; wr(6'h04, dir_m);
        out_m = $urandom & M; wr(6'h08, out_m);
        en_m  = $urandom & M; wr(6'h18, en_m);
        pol_m = $urandom & M; wr(6'h20, pol_m);
        repeat (4) @(negedge HCLK);
        for (int n = 0; n < 60; n++) begin
            if (n % 8 == 7) begin
                logic [31:0] old, rise, fall;
                old = pins;
                pins = $urandom & M;
                rise = pins & ~old;
                fall = ~pins & old;
                @(negedge HCLK); RDATA = pins[W-1:0];
                repeat (5) @(negedge HCLK);
                sticky_m |= type_m & ((both_m & (rise | fall)) | (~both_m & ((pol_m & rise) | (~pol_m & fall))));
            end else if ($urandom_range(0, 2) == 0) begin
                int idx;
                idx = $urandom_range(0, 15);
                rd_chk($sformatf("rnd_rd_%0h", idx * 4), 6'(idx * 4), read_exp(idx));
            end else begin
                int idx;
                logic [31:0] d, dm;
                idx = $urandom_range(0, 15);
                d = $urandom;
                dm = d & M;
                case (idx)
                    1: dir_m = dm;
                    2: out_m = dm;
                    3: out_m = out_m | dm;
                    4: out_m = out_m & ~dm;
                    5: out_m = out_m ^ dm;
                    6: en_m = dm;
                    7: begin sticky_m = stat_exp(); type_m = dm; end
                    8: pol_m = dm;
                    9: sticky_m = sticky_m & ~dm;
`ifdef GPIO_BOTH_EDGE_EN
                    10: both_m = dm;
`endif
                    default: ;
                endcase
                wr(6'(idx * 4), d);
            end
            repeat (2) @(negedge HCLK);
            chk("rnd_wdata", 32'(WDATA), out_m);
            chk("rnd_dir", 32'(DIR), dir_m);
            chk("rnd_pin_irq", 32'(PIN_IRQ), stat_exp() & en_m);
            @(negedge HCLK);
            chk("rnd_irq", 32'(IRQ), 32'(|(stat_exp() & en_m)));
        end

        // reset during a write data phase drops the write
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h08;
        @(negedge HCLK);
        HSEL = 0; HTRANS = 0; HWRITE = 0; HADDR = 0; HWDATA = 32'hFFFF; HRESETn = 0;
        @(negedge HCLK);
        chk("midrst_wdata", 32'(WDATA), 0);
        HRESETn = 1;
        @(negedge HCLK);
        chk("midrst_wdata_after", 32'(WDATA), 0);
        rd_chk("midrst_data_out", 6'h08, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
